// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bundle: EX-side instruction and control inputs, MEM-side
// registered outputs, forwarding path and trap status.
interface ex_mem_stage_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PC_W   = 16,
   parameter int unsigned REG_W  = 4
);
   logic                  stall;
   logic                  flush;
   logic                  ex_valid;
   logic [PC_W-1:0]       ex_pc;
   logic [2:0]            ex_alu_ctrl;
   logic [2*DATA_W-1:0]   ex_result;
   logic                  ex_overflow;
   logic [REG_W-1:0]      ex_rd;
   logic [REG_W-1:0]      ex_rd2;
   logic                  ex_reg_write;
   logic                  ex_mem_read;
   logic                  ex_mem_write;
   logic [DATA_W-1:0]     ex_store_data;
   logic                  exc_ack;

   logic                  mem_valid;
   logic [2*DATA_W-1:0]   mem_result;
   logic [REG_W-1:0]      mem_rd;
   logic [REG_W-1:0]      mem_rd2;
   logic                  mem_reg_write;
   logic                  mem_reg_write2;
   logic                  mem_mem_read;
   logic                  mem_mem_write;
   logic [DATA_W-1:0]     mem_store_data;
   logic                  fwd_en;
   logic [DATA_W-1:0]     fwd_data;
   logic                  exc_pending;
   logic [PC_W-1:0]       epc;
   logic                  stall_up;

   modport master (
      output stall, flush, ex_valid, ex_pc, ex_alu_ctrl, ex_result, ex_overflow,
             ex_rd, ex_rd2, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_store_data, exc_ack,
      input  mem_valid, mem_result, mem_rd, mem_rd2, mem_reg_write,
             mem_reg_write2, mem_mem_read, mem_mem_write, mem_store_data,
             fwd_en, fwd_data, exc_pending, epc, stall_up
   );

   modport slave (
      input  stall, flush, ex_valid, ex_pc, ex_alu_ctrl, ex_result, ex_overflow,
             ex_rd, ex_rd2, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_store_data, exc_ack,
      output mem_valid, mem_result, mem_rd, mem_rd2, mem_reg_write,
             mem_reg_write2, mem_mem_read, mem_mem_write, mem_store_data,
             fwd_en, fwd_data, exc_pending, epc, stall_up
   );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with MEM->EX forwarding, add/sub overflow trap
// (EPC capture, pipe hold until acknowledge) and SWAP dual writeback.
module ex_mem_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PC_W   = 16,
   parameter int unsigned REG_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   ex_mem_stage_if.slave    bus
);
   localparam int unsigned RES_W = 2 * DATA_W;

   typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

   state_t              state;
   logic                valid_q;
   logic                rw_q;
   logic                rw2_q;
   logic                mr_q;
   logic                mw_q;
   logic                exc_q;
   logic [RES_W-1:0]    result_q;
   logic [REG_W-1:0]    rd_q;
   logic [REG_W-1:0]    rd2_q;
   logic [DATA_W-1:0]   sd_q;
   logic [PC_W-1:0]     epc_q;

   logic capture;
   logic arith;
   logic trap;
   logic bubble;

   assign capture = (state == RUN) & ~bus.stall & ~bus.flush & bus.ex_valid;
   assign arith   = (bus.ex_alu_ctrl == 3'b000) | (bus.ex_alu_ctrl == 3'b001);
   assign trap    = capture & bus.ex_overflow & arith;
   // Flush wins over stall; a stalled, unflushed stage keeps its contents.
   assign bubble  = bus.flush | (~bus.stall & ~capture) | trap;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         valid_q  <= 1'b0;
         rw_q     <= 1'b0;
         rw2_q    <= 1'b0;
         mr_q     <= 1'b0;
         mw_q     <= 1'b0;
         exc_q    <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
         rd2_q    <= '0;
         sd_q     <= '0;
         epc_q    <= '0;
      end else begin
         case (state)
            RUN: begin
               if (bubble) begin
                  valid_q <= 1'b0;
                  rw_q    <= 1'b0;
                  rw2_q   <= 1'b0;
                  mr_q    <= 1'b0;
                  mw_q    <= 1'b0;
               end else if (capture) begin
                  valid_q  <= 1'b1;
                  result_q <= bus.ex_result;
                  rd_q     <= bus.ex_rd;
                  rd2_q    <= bus.ex_rd2;
                  rw_q     <= bus.ex_reg_write;
                  rw2_q    <= bus.ex_reg_write & (bus.ex_alu_ctrl == 3'b011);
                  mr_q     <= bus.ex_mem_read;
                  mw_q     <= bus.ex_mem_write;
                  sd_q     <= bus.ex_store_data;
               end
               if (trap) begin
                  epc_q <= bus.ex_pc;
                  exc_q <= 1'b1;
                  state <= TRAP;
               end
            end
            TRAP: begin
               // EX inputs are ignored while trapped, including the ack cycle.
               valid_q <= 1'b0;
               rw_q    <= 1'b0;
               rw2_q   <= 1'b0;
               mr_q    <= 1'b0;
               mw_q    <= 1'b0;
               if (bus.exc_ack) begin
                  exc_q <= 1'b0;
                  state <= RUN;
               end
            end
         endcase
      end
   end

   assign bus.mem_valid      = valid_q;
   assign bus.mem_result     = result_q;
   assign bus.mem_rd         = rd_q;
   assign bus.mem_rd2        = rd2_q;
   assign bus.mem_reg_write  = rw_q;
   assign bus.mem_reg_write2 = rw2_q;
   assign bus.mem_mem_read   = mr_q;
   assign bus.mem_mem_write  = mw_q;
   assign bus.mem_store_data = sd_q;
   assign bus.fwd_en         = valid_q & rw_q & ~mr_q;
   assign bus.fwd_data       = result_q[DATA_W-1:0];
   assign bus.exc_pending    = exc_q;
   assign bus.epc            = epc_q;
   assign bus.stall_up       = (state == TRAP);
endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a behavioural model predicts the
// registered outputs each cycle; predictions are queued and checked after the edge.
module tb_ex_mem_stage;
   logic clk;
   logic rst;

   ex_mem_stage_if #(.DATA_W(16), .PC_W(16), .REG_W(4)) bus ();

   ex_mem_stage #(.DATA_W(16), .PC_W(16), .REG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] result;
      logic [3:0]  rd;
      logic [3:0]  rd2;
      logic        rw;
      logic        rw2;
      logic        mr;
      logic        mw;
      logic [15:0] sd;
      logic        fwd_en;
      logic [15:0] fwd_data;
      logic        exc;
      logic [15:0] epc;
      logic        stall_up;
   } exp_t;

   exp_t m;
   logic m_trap;
   exp_t sb_q[$];
   int   n_cmp;
   int   n_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_bubble();
      m.valid = 1'b0;
      m.rw    = 1'b0;
      m.rw2   = 1'b0;
      m.mr    = 1'b0;
      m.mw    = 1'b0;
   endtask

   // Predict the stage state after the coming rising edge.
   task automatic model_step();
      if (rst) begin
         m = '{default: '0};
         m_trap = 1'b0;
      end else if (m_trap) begin
         model_bubble();
         if (bus.exc_ack) begin
            m.exc  = 1'b0;
            m_trap = 1'b0;
         end
      end else if (bus.flush) begin
         model_bubble();
      end else if (bus.stall) begin
         // hold
      end else if (!bus.ex_valid) begin
         model_bubble();
      end else if (bus.ex_overflow && (bus.ex_alu_ctrl == 3'd0 || bus.ex_alu_ctrl == 3'd1)) begin
         model_bubble();
         m.epc  = bus.ex_pc;
         m.exc  = 1'b1;
         m_trap = 1'b1;
      end else begin
         m.valid  = 1'b1;
         m.result = bus.ex_result;
         m.rd     = bus.ex_rd;
         m.rd2    = bus.ex_rd2;
         m.rw     = bus.ex_reg_write;
         m.rw2    = bus.ex_reg_write && (bus.ex_alu_ctrl == 3'd3);
         m.mr     = bus.ex_mem_read;
         m.mw     = bus.ex_mem_write;
         m.sd     = bus.ex_store_data;
      end
      m.fwd_en   = m.valid & m.rw & ~m.mr;
      m.fwd_data = m.result[15:0];
      m.stall_up = m_trap;
   endtask

   task automatic compare(input exp_t e);
      chk("valid",    64'(bus.mem_valid),      64'(e.valid));
      chk("rw",       64'(bus.mem_reg_write),  64'(e.rw));
      chk("rw2",      64'(bus.mem_reg_write2), 64'(e.rw2));
      chk("mr",       64'(bus.mem_mem_read),   64'(e.mr));
      chk("mw",       64'(bus.mem_mem_write),  64'(e.mw));
      chk("fwd_en",   64'(bus.fwd_en),         64'(e.fwd_en));
      chk("exc",      64'(bus.exc_pending),    64'(e.exc));
      chk("epc",      64'(bus.epc),            64'(e.epc));
      chk("stall_up", 64'(bus.stall_up),       64'(e.stall_up));
      if (e.valid) begin
         chk("result",   64'(bus.mem_result),     64'(e.result));
         chk("rd",       64'(bus.mem_rd),         64'(e.rd));
         chk("rd2",      64'(bus.mem_rd2),        64'(e.rd2));
         chk("sd",       64'(bus.mem_store_data), 64'(e.sd));
         chk("fwd_data", 64'(bus.fwd_data),       64'(e.fwd_data));
      end
   endtask

   task automatic cycle();
      exp_t e;
      model_step();
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      compare(e);
   endtask

   task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] r,
                        input logic o, input logic [3:0] d, input logic [3:0] d2,
                        input logic w, input logic rd_mem, input logic wr_mem,
                        input logic [15:0] s, input logic [15:0] pc);
      bus.ex_valid      = v;
      bus.ex_alu_ctrl   = c;
      bus.ex_result     = r;
      bus.ex_overflow   = o;
      bus.ex_rd         = d;
      bus.ex_rd2        = d2;
      bus.ex_reg_write  = w;
      bus.ex_mem_read   = rd_mem;
      bus.ex_mem_write  = wr_mem;
      bus.ex_store_data = s;
      bus.ex_pc         = pc;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_result"}, 64'(bus.mem_result),     64'h0);
      chk({tag, "_rd"},     64'(bus.mem_rd),         64'h0);
      chk({tag, "_rd2"},    64'(bus.mem_rd2),        64'h0);
      chk({tag, "_sd"},     64'(bus.mem_store_data), 64'h0);
      chk({tag, "_fwd"},    64'(bus.fwd_data),       64'h0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      m = '{default: '0};
      m_trap = 1'b0;
      rst = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.exc_ack = 1'b0;
      idle();
      cycle();
      cycle();
      check_zero("reset");
      rst = 1'b0;

      // Add 1+1 with forwarding.
      drive(1'b1, 3'd0, 32'h0000_0002, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0010);
      cycle();
      chk("t1_fwd_data", 64'(bus.fwd_data), 64'h2);
      chk("t1_fwd_en",   64'(bus.fwd_en),   64'h1);

      // Overflowing add traps; EX inputs ignored while trapped.
      drive(1'b1, 3'd0, 32'h0001_FFFE, 1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0040);
      cycle();
      chk("t2_epc",      64'(bus.epc),         64'h40);
      chk("t2_stall_up", 64'(bus.stall_up),    64'h1);
      drive(1'b1, 3'd4, 32'h0000_1234, 1'b0, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0044);
      repeat (3) cycle();
      bus.exc_ack = 1'b1;
      cycle();
      chk("t2_ack_exc", 64'(bus.exc_pending), 64'h0);
      chk("t2_ack_mv",  64'(bus.mem_valid),   64'h0);
      bus.exc_ack = 1'b0;
      cycle();
      chk("t2_resume_mv", 64'(bus.mem_valid), 64'h1);

      // AND with overflow flag set must not trap.
      drive(1'b1, 3'd4, 32'h0000_00F0, 1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0048);
      cycle();
      chk("t3_exc", 64'(bus.exc_pending), 64'h0);

      // Swap dual writeback.
      drive(1'b1, 3'd3, 32'h0005_0002, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0, 16'h004C);
      cycle();
      chk("t4_result", 64'(bus.mem_result),     64'h0005_0002);
      chk("t4_rw2",    64'(bus.mem_reg_write2), 64'h1);

      // Store captured, then held through stall, then flushed under stall.
      drive(1'b1, 3'd2, 32'h0000_0BEE, 1'b0, 4'd9, 4'd0, 1'b0, 1'b0, 1'b1, 16'hCAFE, 16'h0050);
      cycle();
      drive(1'b1, 3'd1, 32'h0000_0777, 1'b1, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h0054);
      bus.stall = 1'b1;
      repeat (2) cycle();
      chk("t5_hold_sd", 64'(bus.mem_store_data), 64'hCAFE);
      bus.flush = 1'b1;
      cycle();
      chk("t5_flush_mv", 64'(bus.mem_valid), 64'h0);
      bus.stall = 1'b0;
      bus.flush = 1'b0;

      // Reset during trap, then a load must not forward.
      drive(1'b1, 3'd1, 32'h0000_8000, 1'b1, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0060);
      cycle();
      rst = 1'b1;
      cycle();
      check_zero("t6");
      chk("t6_stall_up", 64'(bus.stall_up), 64'h0);
      rst = 1'b0;
      drive(1'b1, 3'd0, 32'h0000_0100, 1'b0, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0064);
      cycle();
      chk("t6_load_fwd", 64'(bus.fwd_en), 64'h0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 5)), 32'($urandom),
               1'($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
               16'($urandom), 16'($urandom));
         bus.stall   = 1'($urandom_range(0, 4) == 0);
         bus.flush   = 1'($urandom_range(0, 7) == 0);
         bus.exc_ack = 1'($urandom_range(0, 2) == 0);
         rst         = 1'($urandom_range(0, 49) == 0);
         cycle();
      end
      rst = 1'b0;

      chk("sb_empty", 64'(sb_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
